// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the mem_line_responder slice.
// Optional build macro: MEM_CRITICAL_WORD_FIRST_EN (critical-word-first fills).
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    RD_BURST = 2'd2,
    WR_BURST = 2'd3
  } state_e;

  // Beat-offset width inside a line (WORDS_PER_LINE is a power of two).
  function automatic int unsigned calc_offset_w(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Line-index width: word address bits left above the beat offset.
  function automatic int unsigned calc_line_w(input int unsigned addr_width,
                                              input int unsigned words_per_line);
    return addr_width - $clog2(words_per_line);
  endfunction

  // Default data for a never-written word: its own (zero-extended) word address.
  // Callers zero-extend into 64 bits and cast down to their data width (<= 64).
  function automatic logic [63:0] pattern_word(input logic [63:0] word_addr);
    return word_addr;
  endfunction

endpackage

// File: rtl/mem_line_store.sv
// Word array with per-line written flags, one write port and a registered
// read port. Unwritten lines read back as their address pattern.
// clr_n clears every written flag and the read register asynchronously.
module mem_line_store
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OFFSET_W   = 2
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  set_flag,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned LINE_W = ADDR_WIDTH - OFFSET_W;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned LINES  = 2 ** LINE_W;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [LINES-1:0]      written_q, written_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [LINE_W-1:0]     wr_line, rd_line;

  // Line indices of the write and read addresses.
  always_comb begin
    wr_line = waddr[ADDR_WIDTH-1:OFFSET_W];
    rd_line = rd_addr[ADDR_WIDTH-1:OFFSET_W];
  end

  // Array contents are deliberately not reset; the flags gate visibility.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Next written-flag vector and next read register value.
  always_comb begin
    written_d = written_q;
    if (set_flag) begin
      written_d[wr_line] = 1'b1;
    end
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = written_q[rd_line] ? mem_q[rd_addr]
                                     : DATA_WIDTH'(pattern_word(64'(rd_addr)));
    end
  end

  // Flags and read register, both cleared by clr_n.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      written_q <= '0;
      rd_data_q <= '0;
    end else begin
      written_q <= written_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_line_responder.sv
// Backing-memory line responder: line fills return a WORDS_PER_LINE burst
// LATENCY cycles after accept; write-backs store a full line.
// Optional build macro: MEM_CRITICAL_WORD_FIRST_EN -- fill bursts start at the
// requested word and wrap within the line; otherwise they start at word 0.
module mem_line_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned LATENCY        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  input  logic                  rsp_ready,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  busy
);

  localparam int unsigned OFFSET_W = calc_offset_w(WORDS_PER_LINE);
  localparam int unsigned LINE_W   = calc_line_w(ADDR_WIDTH, WORDS_PER_LINE);
  localparam int unsigned LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  localparam bit CWF_EN = 1'b1;
`else
  localparam bit CWF_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_last_q, rsp_last_d;
  logic                wr_ready_q, wr_ready_d;
  logic                busy_q, busy_d;

  logic                  rd_en, we, set_flag;
  logic [OFFSET_W-1:0]   start_off, rd_off;
  logic [ADDR_WIDTH-1:0] rd_addr, waddr;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    off_d     = off_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    rd_en     = 1'b0;
    we        = 1'b0;
    set_flag  = 1'b0;
    start_off = CWF_EN ? off_q : '0;
    rd_off    = start_off;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          line_d = req_addr[ADDR_WIDTH-1:OFFSET_W];
          off_d  = req_addr[OFFSET_W-1:0];
          beat_d = '0;
          if (req_write) begin
            state_d = WR_BURST;
          end else begin
            state_d = WAIT;
            lat_d   = LAT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          // Fetch beat 0 now so its data is registered when RD_BURST begins.
          state_d = RD_BURST;
          rd_en   = 1'b1;
          rd_off  = start_off;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RD_BURST: begin
        if (rsp_valid_q && rsp_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == '1) begin
            state_d = IDLE;
          end else begin
            // Prefetch the next beat on the handshake: no gap between beats.
            rd_en  = 1'b1;
            rd_off = start_off + beat_d;
          end
        end
      end
      WR_BURST: begin
        if (wr_valid && wr_ready_q) begin
          we     = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == '1) begin
            set_flag = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rd_addr = {line_q, rd_off};
    waddr   = {line_q, beat_q};

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RD_BURST);
    rsp_last_d  = (state_d == RD_BURST) && (beat_d == '1);
    wr_ready_d  = (state_d == WR_BURST);
    busy_d      = (state_d != IDLE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_q      <= '0;
      off_q       <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      off_q       <= off_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
    end
  end

  mem_line_store #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .OFFSET_W  (OFFSET_W)
  ) u_store (
    .clk     (clk),
    .clr_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wr_data),
    .set_flag(set_flag),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rsp_data)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: a transaction-level memory model
// predicts every cycle's outputs; directed cases pin the model with literals.
`timescale 1ns/1ps
module tb_mem_line_responder;

  localparam int unsigned AW  = 11;
  localparam int unsigned DW  = 32;
  localparam int unsigned W   = 4;
  localparam int unsigned LAT = 4;
  localparam int unsigned OW  = 2;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          rsp_ready = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          req_ready, rsp_valid, rsp_last, wr_ready, busy;
  logic [DW-1:0] rsp_data;

  int total = 0;
  int bad   = 0;

  mem_line_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .WORDS_PER_LINE(W),
    .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem  [0:(1<<AW)-1];
  bit            m_flag [0:(1<<(AW-OW))-1];
  bit            m_rd, m_wr, prev_rst, idle_now, first_seen;
  int            m_wait, m_wbeat, m_wline;
  int            cyc, acc_cyc, first_cyc;
  int            ln, wa, o;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got[$];

  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
  end

  // Compare process: sample everything at the falling edge, then advance the
  // model by what the coming rising edge will do.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_last", rsp_last, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_busy", busy, 0);
      m_rd = 0; m_wr = 0; exp_q.delete(); prev_rst = 0;
      foreach (m_flag[i]) m_flag[i] = 0;
    end else begin
      idle_now = !(m_rd || m_wr) && prev_rst;
      chk("req_ready", req_ready, idle_now);
      chk("busy", busy, m_rd || m_wr);
      chk("rsp_valid", rsp_valid, m_rd && m_wait == 0);
      if (m_rd && m_wait == 0) begin
        if (!first_seen) begin first_seen = 1; first_cyc = cyc; end
        chk("rsp_data", rsp_data, exp_q[0]);
        chk("rsp_last", rsp_last, exp_q.size() == 1);
        if (rsp_ready) begin
          got.push_back(rsp_data);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_rd = 0;
        end
      end else if (m_rd) begin
        m_wait--;
      end
      chk("wr_ready", wr_ready, m_wr);
      if (m_wr && wr_valid) begin
        m_mem[m_wline * W + m_wbeat] = wr_data;
        m_wbeat++;
        if (m_wbeat == W) begin m_flag[m_wline] = 1; m_wr = 0; end
      end
      if (idle_now && req_valid) begin
        acc_cyc = cyc; first_seen = 0;
        ln = int'(req_addr) / W;
        if (req_write) begin
          m_wr = 1; m_wbeat = 0; m_wline = ln;
        end else begin
          m_rd = 1; m_wait = LAT; exp_q.delete();
          for (int k = 0; k < W; k++) begin
            o  = CWF ? ((int'(req_addr) % W) + k) % W : k;
            wa = ln * W + o;
            exp_q.push_back(m_flag[ln] ? m_mem[wa] : DW'(wa));
          end
        end
      end
      prev_rst = 1;
    end
  end

  // ---------------- stimulus ----------------
  bit rand_bp = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      step();
      if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input bit wr, input logic [AW-1:0] a);
    int n = 0;
    req_valid = 1; req_write = wr; req_addr = a;
    while (!req_ready && n < 300) begin step(); n++; end
    if (n >= 300) chk("accept_timeout", req_ready, 1);
    step();
    req_valid = 0;
  endtask

  task automatic write_beats(input logic [DW-1:0] base, input bit gaps);
    int n;
    for (int b = 0; b < W; b++) begin
      if (gaps) begin
        wr_valid = 0;
        repeat ($urandom_range(0, 2)) step();
      end
      wr_valid = 1; wr_data = base + DW'(b);
      n = 0;
      while (!wr_ready && n < 300) begin step(); n++; end
      if (n >= 300) chk("wr_ready_timeout", wr_ready, 1);
      step();
    end
    wr_valid = 0;
  endtask

  task automatic wait_beats(input int cnt);
    int n = 0;
    while (got.size() < cnt && n < 400) begin step(); n++; end
    if (n >= 400) chk("beats_timeout", got.size(), cnt);
  endtask

  task automatic chk_beats(input string nm, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    logic [DW-1:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_count"}, got.size(), 4);
    for (int k = 0; k < 4; k++) chk({nm, "_beat"}, (k < got.size()) ? got[k] : 'x, e[k]);
  endtask

  initial begin
    int n;
    int lines [8];
    logic [AW-1:0] a;
    lines = '{0, 1, 2, 3, 508, 509, 510, 511};

    // Reset, then fill of 0x020 with the consumer always ready.
    rst_n = 0; rsp_ready = 1;
    repeat (3) step();
    chk("reset_req_ready", req_ready, 0);
    rst_n = 1;
    got.delete(); issue(0, 11'h020); wait_beats(4);
    chk_beats("fill_020", 32'h20, 32'h21, 32'h22, 32'h23);
    chk("fill_020_latency", first_cyc - acc_cyc - 1, 4);
    chk("ready_after_burst", req_ready, 1);

    // Write-back then fill of the same line; neighbour line still patterned.
    issue(1, 11'h040); write_beats(32'hDEADBEE0, 0);
    got.delete(); issue(0, 11'h040); wait_beats(4);
    chk_beats("wb_fill_040", 32'hDEADBEE0, 32'hDEADBEE1, 32'hDEADBEE2, 32'hDEADBEE3);
    got.delete(); issue(0, 11'h060); wait_beats(4);
    chk_beats("fill_060", 32'h60, 32'h61, 32'h62, 32'h63);

    // Consumer stall for three cycles while beat 1 is presented.
    got.delete(); issue(0, 11'h080); wait_beats(1);
    rsp_ready = 0;
    repeat (3) step();
    chk("stall_valid", rsp_valid, 1);
    chk("stall_data", rsp_data, 32'h81);
    rsp_ready = 1;
    wait_beats(4);
    chk_beats("stall_080", 32'h80, 32'h81, 32'h82, 32'h83);

    // Second request held while the first burst is in flight.
    got.delete(); issue(0, 11'h0A0);
    req_valid = 1; req_write = 0; req_addr = 11'h0C0;
    n = 0;
    while (!req_ready && n < 300) begin step(); n++; end
    chk("held_req_first_done", got.size(), 4);
    step(); req_valid = 0;
    wait_beats(8);
    for (int k = 0; k < 8; k++)
      chk("held_req_beat", (k < got.size()) ? got[k] : 'x, (k < 4) ? 32'hA0 + k : 32'hC0 + k - 4);

    // Reset in the middle of a fill: outputs drop at once, flags are lost.
    issue(1, 11'h040); write_beats(32'h12345670, 0);
    got.delete(); issue(0, 11'h040); wait_beats(2);
    chk("pre_rst_valid", rsp_valid, 1);
    rst_n = 0; #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_last", rsp_last, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    step(); step();
    rst_n = 1;
    got.delete(); issue(0, 11'h040); wait_beats(4);
    chk_beats("post_rst_040", 32'h40, 32'h41, 32'h42, 32'h43);

    // Fill addressed at word 2 of its line.
    got.delete(); issue(0, 11'h062); wait_beats(4);
    if (CWF) chk_beats("fill_062", 32'h62, 32'h63, 32'h60, 32'h61);
    else     chk_beats("fill_062", 32'h60, 32'h61, 32'h62, 32'h63);

    // Randomized traffic over low and top lines with back-pressure and write gaps.
    rand_bp = 1;
    for (int t = 0; t < 60; t++) begin
      a = AW'(lines[$urandom_range(0, 7)] * W + $urandom_range(0, W - 1));
      if ($urandom_range(0, 1) == 1) begin
        issue(1, a); write_beats($urandom, 1);
      end else begin
        got.delete(); issue(0, a); wait_beats(4);
      end
    end
    rand_bp = 0; rsp_ready = 1;
    n = 0;
    while (busy && n < 300) begin step(); n++; end
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
